// File: rtl/hc21_ste_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hc21_ste_bus_ctrl
// Purpose  : STEBus master cycle sequencer for the HC21-STE CPU board.
//            Stalls the CPU on a STEBus window access, runs the STEBus
//            DATSTB*/DATACK* handshake, captures read data and then
//            releases the CPU.
// Options  : HC21_STE_TIMEOUT_EN - when defined, a watchdog aborts strobes
//            that no slave acknowledges and sets the sticky bus_err flag.
// Revision : 1.0 - initial release
// ============================================================================
module hc21_ste_bus_ctrl #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       sysclk,
    input  logic       sysrst,
    input  logic       sel_stebus_n,
    input  logic       cpu_mreq_n,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    output logic       cpu_wait_n,
    output logic [7:0] cpu_d_out,
    output logic       cpu_d_oe_n,
    input  logic [7:0] ste_d_in,
    output logic       ste_adr_oe_n,
    output logic       ste_dat_oe_n,
    output logic [2:0] ste_cm,
    output logic       ste_datstb_n,
    input  logic       ste_datack_n,
    output logic       bus_err,
    input  logic       bus_err_clr
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_STROBE = 3'd2;
    localparam logic [2:0] c_ST_ACK    = 3'd3;
`ifdef HC21_STE_TIMEOUT_EN
    localparam logic [2:0] c_ST_ERR    = 3'd4;
`endif
    localparam logic [2:0] c_ST_DONE   = 3'd5;

    localparam logic [2:0] c_CM_READ   = 3'b111;
    localparam logic [2:0] c_CM_WRITE  = 3'b110;
    localparam logic [2:0] c_CM_IDLE   = 3'b000;

    // Last counter value of the address/command setup phase.
    localparam logic [7:0] c_SETUP_LAST = 8'(SETUP_CYCLES - 1);
`ifdef HC21_STE_TIMEOUT_EN
    // Strobe counter value at which the watchdog gives up.
    localparam logic [7:0] c_TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [7:0] c_unused_to  = 8'(TIMEOUT_CYCLES);
`endif

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       w_req;
    logic       r_req;
    logic       r_req_rd;
    logic       r_rd;
    logic       r_ack_s1;
    logic       r_ack_s2;
    logic       w_ack;
    logic [7:0] r_cnt;
    logic [7:0] r_d_out;
    logic       w_setup_done;
    logic       w_timeout;

    assign w_req        = !sel_stebus_n && !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    assign w_ack        = !r_ack_s2;
    assign w_setup_done = (r_cnt == c_SETUP_LAST);

`ifdef HC21_STE_TIMEOUT_EN
    assign w_timeout = (r_state == c_ST_STROBE) && !w_ack && (r_cnt == c_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    assign cpu_d_out = r_d_out;

    // Register the CPU request/direction and synchronize the asynchronous DATACK*.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_req    <= 1'b0;
            r_req_rd <= 1'b0;
            r_ack_s1 <= 1'b1;
            r_ack_s2 <= 1'b1;
        end else begin
            r_req    <= w_req;
            r_req_rd <= !cpu_rd_n;
            r_ack_s1 <= ste_datack_n;
            r_ack_s2 <= r_ack_s1;
        end
    end

    // State register.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Phase counter: cleared on every state change, counts setup and strobe cycles.
    always_ff @(posedge sysclk) begin
        if (sysrst || (w_next_state != r_state)) begin
            r_cnt <= 8'd0;
        end else if (r_state == c_ST_SETUP) begin
            r_cnt <= r_cnt + 8'd1;
`ifdef HC21_STE_TIMEOUT_EN
        end else if (r_state == c_ST_STROBE) begin
            r_cnt <= r_cnt + 8'd1;
`endif
        end
    end

    // Latch the transfer direction when a request is accepted.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_rd <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && r_req) begin
            r_rd <= r_req_rd;
        end
    end

    // Read data: slave data on the ACK entry edge, all-ones on an aborted read.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_d_out <= 8'h00;
        end else if ((r_state == c_ST_STROBE) && w_ack && r_rd) begin
            r_d_out <= ste_d_in;
        end else if (w_timeout && r_rd) begin
            r_d_out <= 8'hFF;
        end
    end

`ifdef HC21_STE_TIMEOUT_EN
    logic r_bus_err;

    // Sticky timeout flag; a new timeout outranks a simultaneous clear.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end else if (bus_err_clr) begin
            r_bus_err <= 1'b0;
        end
    end

    assign bus_err = r_bus_err;
`else
    logic w_unused_clr;
    assign w_unused_clr = bus_err_clr;
    assign bus_err      = 1'b0;
`endif

    // Next-state logic for the handshake sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_req) begin
                    w_next_state = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                if (w_setup_done) begin
                    w_next_state = c_ST_STROBE;
                end
            end
            c_ST_STROBE: begin
                if (w_ack) begin
                    w_next_state = c_ST_ACK;
`ifdef HC21_STE_TIMEOUT_EN
                end else if (w_timeout) begin
                    w_next_state = c_ST_ERR;
`endif
                end
            end
            c_ST_ACK: begin
                if (!w_ack) begin
                    w_next_state = c_ST_DONE;
                end
            end
`ifdef HC21_STE_TIMEOUT_EN
            c_ST_ERR: begin
                w_next_state = c_ST_DONE;
            end
`endif
            c_ST_DONE: begin
                if (sel_stebus_n || cpu_mreq_n) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Output decode: CPU stall, STEBus buffer enables, command and strobe.
    always_comb begin
        cpu_wait_n   = 1'b1;
        cpu_d_oe_n   = 1'b1;
        ste_adr_oe_n = 1'b1;
        ste_dat_oe_n = 1'b1;
        ste_cm       = c_CM_IDLE;
        ste_datstb_n = 1'b1;
        case (r_state)
            c_ST_SETUP, c_ST_STROBE, c_ST_ACK: begin
                cpu_wait_n   = 1'b0;
                ste_adr_oe_n = 1'b0;
                ste_dat_oe_n = r_rd;
                ste_cm       = r_rd ? c_CM_READ : c_CM_WRITE;
                ste_datstb_n = (r_state != c_ST_STROBE);
            end
`ifdef HC21_STE_TIMEOUT_EN
            c_ST_ERR: begin
                cpu_wait_n   = 1'b0;
                ste_adr_oe_n = 1'b0;
                ste_dat_oe_n = r_rd;
                ste_cm       = r_rd ? c_CM_READ : c_CM_WRITE;
            end
`endif
            c_ST_DONE: begin
                cpu_d_oe_n = !r_rd;
            end
            default: begin
                cpu_wait_n = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hc21_ste_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc21_ste_bus_ctrl
// Purpose  : Directed self-checking bench for hc21_ste_bus_ctrl
//            (SETUP_CYCLES=2, TIMEOUT_CYCLES=16). The watchdog scenario is
//            exercised when HC21_STE_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc21_ste_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_n, mreq_n, rd_n, wr_n;
    logic       wait_n;
    logic [7:0] d_out;
    logic       d_oe_n;
    logic [7:0] d_in;
    logic       adr_oe_n, dat_oe_n;
    logic [2:0] cm;
    logic       datstb_n, datack_n;
    logic       err, err_clr;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    hc21_ste_bus_ctrl #(
        .SETUP_CYCLES   (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .sysclk       (clk),
        .sysrst       (rst),
        .sel_stebus_n (sel_n),
        .cpu_mreq_n   (mreq_n),
        .cpu_rd_n     (rd_n),
        .cpu_wr_n     (wr_n),
        .cpu_wait_n   (wait_n),
        .cpu_d_out    (d_out),
        .cpu_d_oe_n   (d_oe_n),
        .ste_d_in     (d_in),
        .ste_adr_oe_n (adr_oe_n),
        .ste_dat_oe_n (dat_oe_n),
        .ste_cm       (cm),
        .ste_datstb_n (datstb_n),
        .ste_datack_n (datack_n),
        .bus_err      (err),
        .bus_err_clr  (err_clr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cpu_idle();
        sel_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_wait_n"},   {7'd0, wait_n},   8'h01);
        chk({pfx, "_d_out"},    d_out,            8'h00);
        chk({pfx, "_d_oe_n"},   {7'd0, d_oe_n},   8'h01);
        chk({pfx, "_adr_oe_n"}, {7'd0, adr_oe_n}, 8'h01);
        chk({pfx, "_dat_oe_n"}, {7'd0, dat_oe_n}, 8'h01);
        chk({pfx, "_cm"},       {5'd0, cm},       8'h00);
        chk({pfx, "_datstb_n"}, {7'd0, datstb_n}, 8'h01);
        chk({pfx, "_bus_err"},  {7'd0, err},      8'h00);
    endtask

    // Read with a responsive slave; bounded so a stuck design still ends.
    task automatic run_read(input logic [7:0] data);
        logic done;
        done = 1'b0;
        d_in = data;
        sel_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (!datstb_n) datack_n = 1'b0;
            else if (!datack_n) datack_n = 1'b1;
            if (wait_n && !d_oe_n) done = 1'b1;
        end
        chk("rr_reached_done", {7'd0, done}, 8'h01);
    endtask

    initial begin
        int n;
        rst = 1'b1; cpu_idle(); d_in = 8'h00; datack_n = 1'b1; err_clr = 1'b0;
        tick(); tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // ---- read, slave acks 3 cycles after DATSTB* falls, data A5
        d_in = 8'hA5; sel_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        tick();                                                  // P1 request registered
        chk("rd_wait_pre",   {7'd0, wait_n},   8'h01);
        tick();                                                  // P2 SETUP
        chk("rd_wait_setup", {7'd0, wait_n},   8'h00);
        chk("rd_cm",         {5'd0, cm},       8'h07);
        chk("rd_adr_oe",     {7'd0, adr_oe_n}, 8'h00);
        chk("rd_dat_oe",     {7'd0, dat_oe_n}, 8'h01);
        chk("rd_stb_p2",     {7'd0, datstb_n}, 8'h01);
        tick();                                                  // P3
        chk("rd_stb_p3",     {7'd0, datstb_n}, 8'h01);
        tick();                                                  // P4 STROBE
        chk("rd_stb_p4",     {7'd0, datstb_n}, 8'h00);
        tick(); tick();                                          // P6
        datack_n = 1'b0;
        tick(); tick();                                          // P8 synchronizer busy
        chk("rd_stb_p8",     {7'd0, datstb_n}, 8'h00);
        chk("rd_dout_p8",    d_out,            8'h00);
        tick();                                                  // P9 ACK
        chk("rd_stb_ack",    {7'd0, datstb_n}, 8'h01);
        chk("rd_dout_ack",   d_out,            8'hA5);
        chk("rd_wait_ack",   {7'd0, wait_n},   8'h00);
        datack_n = 1'b1;
        tick(); tick();                                          // P11 still ACK
        chk("rd_wait_p11",   {7'd0, wait_n},   8'h00);
        tick();                                                  // P12 DONE
        chk("rd_wait_done",  {7'd0, wait_n},   8'h01);
        chk("rd_cm_done",    {5'd0, cm},       8'h00);
        chk("rd_adr_done",   {7'd0, adr_oe_n}, 8'h01);
        chk("rd_doe_done",   {7'd0, d_oe_n},   8'h00);
        chk("rd_dout_done",  d_out,            8'hA5);
        chk("rd_err_done",   {7'd0, err},      8'h00);
        cpu_idle();
        tick();
        chk("rd_doe_idle",   {7'd0, d_oe_n},   8'h01);
        tick();

        // ---- write
        d_in = 8'h11; sel_n = 1'b0; mreq_n = 1'b0; wr_n = 1'b0;
        tick(); tick();                                          // P2 SETUP
        chk("wr_cm",         {5'd0, cm},       8'h06);
        chk("wr_dat_oe_p2",  {7'd0, dat_oe_n}, 8'h00);
        chk("wr_wait",       {7'd0, wait_n},   8'h00);
        tick();                                                  // P3
        chk("wr_stb_p3",     {7'd0, datstb_n}, 8'h01);
        chk("wr_dat_oe_p3",  {7'd0, dat_oe_n}, 8'h00);
        tick();                                                  // P4 STROBE
        chk("wr_stb_p4",     {7'd0, datstb_n}, 8'h00);
        chk("wr_dat_oe_p4",  {7'd0, dat_oe_n}, 8'h00);
        datack_n = 1'b0;
        tick(); tick(); tick();                                  // P7 ACK
        chk("wr_stb_ack",    {7'd0, datstb_n}, 8'h01);
        chk("wr_dat_oe_ack", {7'd0, dat_oe_n}, 8'h00);
        chk("wr_cm_ack",     {5'd0, cm},       8'h06);
        datack_n = 1'b1;
        tick(); tick(); tick();                                  // P10 DONE
        chk("wr_wait_done",  {7'd0, wait_n},   8'h01);
        chk("wr_dat_oe_dn",  {7'd0, dat_oe_n}, 8'h01);
        chk("wr_doe_done",   {7'd0, d_oe_n},   8'h01);
        chk("wr_dout_kept",  d_out,            8'hA5);
        cpu_idle();
        tick(); tick();

        // ---- DATACK* already low at STROBE entry, then held after strobe rises
        d_in = 8'h3C; sel_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        tick(); tick();                                          // P2 SETUP
        datack_n = 1'b0;
        tick(); tick();                                          // P4 STROBE
        chk("hold_stb_p4",   {7'd0, datstb_n}, 8'h00);
        tick();                                                  // P5 ACK
        chk("hold_stb_p5",   {7'd0, datstb_n}, 8'h01);
        chk("hold_dout",     d_out,            8'h3C);
        tick(); tick(); tick();                                  // P8 held in ACK
        chk("hold_wait_p8",  {7'd0, wait_n},   8'h00);
        chk("hold_stb_p8",   {7'd0, datstb_n}, 8'h01);
        datack_n = 1'b1;
        tick(); tick();                                          // P10
        chk("hold_wait_p10", {7'd0, wait_n},   8'h00);
        tick();                                                  // P11 DONE
        chk("hold_wait_dn",  {7'd0, wait_n},   8'h01);
        chk("hold_doe_dn",   {7'd0, d_oe_n},   8'h00);
        cpu_idle();
        tick(); tick();

        // ---- low-memory access: no STEBus activity
        sel_n = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lo_wait",   {7'd0, wait_n},   8'h01);
            chk("lo_adr_oe", {7'd0, adr_oe_n}, 8'h01);
        end
        chk("lo_datstb", {7'd0, datstb_n}, 8'h01);
        cpu_idle();
        tick();

`ifdef HC21_STE_TIMEOUT_EN
        // ---- no acknowledge: watchdog after 16 strobe cycles
        d_in = 8'h42; sel_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        tick(); tick(); tick(); tick();                          // P4 STROBE
        n = 0;
        while (datstb_n == 1'b0 && n < 40) begin
            n++;
            tick();
        end
        chk("to_stb_len",    8'(n),            8'd16);
        chk("to_err_set",    {7'd0, err},      8'h01);
        tick();                                                  // DONE
        chk("to_wait_done",  {7'd0, wait_n},   8'h01);
        chk("to_dout",       d_out,            8'hFF);
        chk("to_doe",        {7'd0, d_oe_n},   8'h00);
        cpu_idle();
        tick();
        chk("to_err_sticky", {7'd0, err},      8'h01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_err_clr",    {7'd0, err},      8'h00);
        tick();
`else
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("noto_err",      {7'd0, err},      8'h00);
`endif

        // ---- reset during STROBE, slave acks as reset hits
        d_in = 8'h77; sel_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        tick(); tick(); tick(); tick();                          // P4 STROBE
        chk("mr_stb",        {7'd0, datstb_n}, 8'h00);
        rst = 1'b1; datack_n = 1'b0; cpu_idle();
        tick();
        check_reset_outputs("mr");
        rst = 1'b0; datack_n = 1'b1;
        tick(); tick(); tick();
        run_read(8'h5A);
        chk("mr_next_dout",  d_out,            8'h5A);
        chk("mr_next_err",   {7'd0, err},      8'h00);
        cpu_idle(); datack_n = 1'b1;
        tick();
        chk("mr_next_idle",  {7'd0, wait_n},   8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
